uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receive stage; consumes the tx line of the UART transmitter.
//  Frame format:
//   - start bit (0)
//   - 8 data bits, LSB first
//   - parity bit = ~^data (XNOR of the 8 data bits)
//   - stop bit (1)
//  Samples the line mid-bit in the system clock domain and checks parity and stop bit.
//  Holds each received byte for a read handshake with the downstream consumer.
// PARAMETERS
//  CLKS_PER_BIT  2  clk cycles per serial bit (>=2); 2 matches a clk/2 bit clock
// PORTS
//  clk           in   1  system clock; all logic on posedge
//  rst_n         in   1  asynchronous, active-low reset
//  rx            in   1  serial input; idles high; asynchronous to clk
//  data_read     in   1  consumer pulse: current byte taken, clear data_valid
//  data_out      out  8  last accepted byte
//  data_valid    out  1  high from frame acceptance until data_read
//  parity_error  out  1  parity status of the byte in data_out; updated with data_out
//  framing_error out  1  one-cycle pulse: stop bit sampled low
//  busy          out  1  high while the FSM is not in IDLE
// BEHAVIOUR
//  Reset values:
//   - data_out=0, data_valid=0, parity_error=0, framing_error=0, busy=0
//   - FSM=IDLE, sync flops=1
//  Synchronisation and sampling:
//   - rx passes through a 2-FF synchronizer (reset to 1).
//   - A start is detected on a synced 1->0 transition while in IDLE.
//   - HALF = CLKS_PER_BIT/2.
//   - Sample k (k=0 start, 1..8 data, 9 parity, 10 stop) is taken at detect + HALF + k*CLKS_PER_BIT cycles.
//  FSM states and transitions:
//   - IDLE->START on detect; clears baud counter.
//   - START: at the sample point, line low -> DATA (bit_idx=0); line high -> IDLE (glitch, no flags).
//   - DATA: shift the sample into shreg[bit_idx]. After bit_idx==7 -> PARITY.
//   - PARITY: store the sampled bit -> STOP.
//   - STOP, line high:
//     - accept the frame: data_out<=shreg, data_valid<=1, parity_error<=(sample != ~^shreg);
//     - then -> IDLE.
//     - data_valid rises 1 clk after the stop sample.
//   - STOP, line low:
//     - framing_error pulses 1 cycle;
//     - data_out, data_valid and parity_error are unchanged;
//     - then -> IDLE.
//     - A line still low keeps the FSM in IDLE until the line is high again (no edge).
//  Handshake:
//   - data_read with data_valid=0 is ignored.
//   - data_read in the same cycle as an acceptance: the new byte loads and data_valid stays 1.
//  Counters:
//   - baud counter width $clog2(CLKS_PER_BIT); resets to 0 at each sample point.
//   - bit_idx is 3 bits and wraps only via the FSM.
//  busy is low in the IDLE cycle after STOP; back-to-back frames are received with no gap beyond the stop bit.
//  Reset mid-frame: all state returns to reset values immediately; the partial frame is lost.
// CONFIGURATION
//  UART_RX_OVERRUN_EN defined:
//   - adds output port overrun (1 bit, reset 0).
//   - Set when a frame is accepted while data_valid=1 and data_read=0.
//   - Sticky until data_read; the new byte still overwrites data_out.
//  UART_RX_OVERRUN_EN undefined:
//   - no overrun port; the unread byte is silently overwritten.
// STRUCTURE
//  uart_pkg:
//   - rx FSM state enum (IDLE, START, DATA, PARITY, STOP)
//   - UART_DATA_BITS=8
//   - UART_IDLE_LEVEL=1
//   - parity function par(d)=~^d
//  Sub-module uart_rx_sync:
//   - 2-FF synchronizer plus falling-edge detect
//   - outputs rx_s and rx_fall
// TESTING (CLKS_PER_BIT=2 unless stated)
//  1. Frame 0xA5 with parity bit 1 and stop 1 -> data_out=0xA5, data_valid=1, parity_error=0, framing_error never high.
//  2. Frame 0x01 with parity bit 1 -> data_valid=1, data_out=0x01, parity_error=1.
//  3. Frame 0x3C with stop bit 0 -> framing_error pulses exactly 1 cycle, data_valid stays 0, data_out keeps its old value.
//  4. CLKS_PER_BIT=8, rx low for 2 cycles then high -> FSM returns to IDLE, no data_valid, no flags.
//  5. Frames 0x11 then 0x22 back-to-back with no data_read -> data_out=0x22, data_valid=1; overrun=1 only with UART_RX_OVERRUN_EN; data_read then clears data_valid (and overrun).
//  6. rst_n low during data bit 4 of a frame -> all outputs 0 next edge; a following clean 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame constants, the
// receiver FSM state encoding and the parity helper.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Receiver FSM states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Parity bit carried by a frame: XNOR of all data bits (odd-style
  // parity, so an all-zero byte sends a 1).
  function automatic logic par(input logic [UART_DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rx line into the clk domain and flags its
// falling edges.
//
// rx_s is the synchronised line delayed by one extra register so that it
// is exactly the "previous" value used by the edge detector. The receiver
// samples rx_s, which keeps every sample point inside its bit even at two
// clocks per bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic meta;
  logic sync;

  // Two-flop synchroniser plus edge-detect register, all reset to the idle level.
  // NOTE: sequential state uses <= so every flop samples the pre-edge value
  // of its neighbour; with = the chain would collapse into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= UART_IDLE_LEVEL;
      sync <= UART_IDLE_LEVEL;
      rx_s <= UART_IDLE_LEVEL;
    end else begin
      meta <= rx;
      sync <= meta;
      rx_s <= sync;
    end
  end

  // High for one cycle when the synchronised line goes from 1 to 0.
  assign rx_fall = rx_s & ~sync;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: start bit, 8 data bits LSB first, XNOR parity bit,
// stop bit. The line is sampled mid-bit in the clk domain; each accepted
// byte is held in data_out with data_valid until the consumer pulses
// data_read.
//
// Optional feature (compile-time macro UART_RX_OVERRUN_EN): adds the
// sticky output 'overrun', set when a new frame lands on an unread byte
// and cleared by data_read. Without the macro an unread byte is silently
// overwritten.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  input  logic                      data_read,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      data_valid,
  output logic                      parity_error,
  output logic                      framing_error,
  output logic                      busy
`ifdef UART_RX_OVERRUN_EN
  ,
  output logic                      overrun
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Start bit is sampled half a bit after detection, later bits one full
  // bit after the previous sample.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic                      rx_s;
  logic                      rx_fall;
  rx_state_e                 state;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      par_bit;
  logic                      sample_tick;
  logic                      stop_tick;
  logic                      accept;
  logic                      frame_bad;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  assign sample_tick = (state == RX_START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);
  assign stop_tick   = (state == RX_STOP) && sample_tick;
  assign accept      = stop_tick && (rx_s == UART_IDLE_LEVEL);
  assign frame_bad   = stop_tick && (rx_s != UART_IDLE_LEVEL);
  assign busy        = (state != RX_IDLE);

  // Baud counter: held at zero while idle, restarts at every sample point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == RX_IDLE || sample_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Frame FSM: advances one field per sample point and assembles the byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (rx_fall) state <= RX_START;
        end
        RX_START: begin
          if (sample_tick) begin
            // A start bit that is already high again was a glitch.
            if (rx_s != UART_IDLE_LEVEL) begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (sample_tick) begin
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state <= RX_PARITY;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        RX_PARITY: begin
          if (sample_tick) begin
            par_bit <= rx_s;
            state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (sample_tick) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Output holding registers: load on a good stop bit, pulse on a bad one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      framing_error <= frame_bad;
      if (accept) begin
        data_out     <= shreg;
        data_valid   <= 1'b1;
        parity_error <= (par_bit != par(shreg));
      end else if (data_read) begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_OVERRUN_EN
  // Sticky overrun: a frame landed on an unread byte; cleared by data_read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (accept && data_valid && !data_read) begin
      overrun <= 1'b1;
    end else if (data_read) begin
      overrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver. One instance runs at two clocks
// per bit, a second at eight clocks per bit for the glitch case.
// Inputs change on the falling clock edge; outputs are read there as well.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       data_read;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  logic       rx8;
  logic       data_read8;
  logic [7:0] data_out8;
  logic       data_valid8;
  logic       parity_error8;
  logic       framing_error8;
  logic       busy8;

`ifdef UART_RX_OVERRUN_EN
  logic       overrun;
  logic       overrun8;
`endif

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int fe8_cnt = 0;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .data_read     (data_read),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .busy          (busy)
`ifdef UART_RX_OVERRUN_EN
    ,
    .overrun       (overrun)
`endif
  );

  uart_receiver #(.CLKS_PER_BIT(8)) dut8 (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx8),
    .data_read     (data_read8),
    .data_out      (data_out8),
    .data_valid    (data_valid8),
    .parity_error  (parity_error8),
    .framing_error (framing_error8),
    .busy          (busy8)
`ifdef UART_RX_OVERRUN_EN
    ,
    .overrun       (overrun8)
`endif
  );

  // Count cycles with framing_error high on each instance.
  always @(negedge clk) begin
    if (framing_error)  fe_cnt++;
    if (framing_error8) fe8_cnt++;
  end

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [7:0] exp_data;
    logic       exp_dv;
    logic       exp_pe;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one full frame on rx (sel=0) or rx8 (sel=1), cpb clocks per bit.
  task automatic drive_frame(input int sel, input logic [7:0] d, input logic p,
                             input logic s, input int cpb);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (sel == 0) rx = bits[i];
      else          rx8 = bits[i];
      tick(cpb);
    end
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    tick(1);
    data_read = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [10:0] bits;

    rst_n      = 1'b0;
    rx         = 1'b1;
    rx8        = 1'b1;
    data_read  = 1'b0;
    data_read8 = 1'b0;

    // Parity bit column is the correct ~^d unless the vector targets an error.
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1};
    vecs[3] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0};

    tick(2);
    check("rst_data_out",  32'(data_out),      32'h0);
    check("rst_valid",     32'(data_valid),    32'h0);
    check("rst_parity",    32'(parity_error),  32'h0);
    check("rst_framing",   32'(framing_error), 32'h0);
    check("rst_busy",      32'(busy),          32'h0);
    check("rst_busy8",     32'(busy8),         32'h0);
    check("rst_valid8",    32'(data_valid8),   32'h0);
    rst_n = 1'b1;
    tick(2);

    // Single frames from the table.
    for (int i = 0; i < 6; i++) begin
      read_pulse();
      check($sformatf("v%0d_cleared", i), 32'(data_valid), 32'h0);
      base = fe_cnt;
      drive_frame(0, vecs[i].d, vecs[i].p, vecs[i].s, 2);
      tick(1);
      check($sformatf("v%0d_valid_not_early", i), 32'(data_valid), 32'h0);
      check($sformatf("v%0d_busy_in_stop", i), 32'(busy), 32'h1);
      tick(1);
      check($sformatf("v%0d_data", i),   32'(data_out),     32'(vecs[i].exp_data));
      check($sformatf("v%0d_valid", i),  32'(data_valid),   32'(vecs[i].exp_dv));
      check($sformatf("v%0d_parity", i), 32'(parity_error), 32'(vecs[i].exp_pe));
      check($sformatf("v%0d_idle", i),   32'(busy),         32'h0);
      tick(2);
      check($sformatf("v%0d_fe_cycles", i), 32'(fe_cnt - base), 32'(vecs[i].exp_fe));
      rx = 1'b1;
      tick(1);
    end

    // Back-to-back frames without a read in between.
    read_pulse();
    drive_frame(0, 8'h11, 1'b1, 1'b1, 2);
    drive_frame(0, 8'h22, 1'b1, 1'b1, 2);
    tick(2);
    check("b2b_data",   32'(data_out),     32'h22);
    check("b2b_valid",  32'(data_valid),   32'h1);
    check("b2b_parity", 32'(parity_error), 32'h0);
`ifdef UART_RX_OVERRUN_EN
    check("b2b_overrun", 32'(overrun), 32'h1);
`endif
    read_pulse();
    check("b2b_read_clears", 32'(data_valid), 32'h0);
`ifdef UART_RX_OVERRUN_EN
    check("b2b_overrun_clear", 32'(overrun), 32'h0);
`endif

    // data_read coinciding with acceptance keeps the new byte valid.
    drive_frame(0, 8'h33, 1'b1, 1'b1, 2);
    tick(2);
    check("pre_read_valid", 32'(data_valid), 32'h1);
    drive_frame(0, 8'h66, 1'b1, 1'b1, 2);
    tick(1);
    data_read = 1'b1;
    tick(1);
    data_read = 1'b0;
    check("coread_data",  32'(data_out),   32'h66);
    check("coread_valid", 32'(data_valid), 32'h1);
`ifdef UART_RX_OVERRUN_EN
    check("coread_no_overrun", 32'(overrun), 32'h0);
`endif
    tick(1);
    check("coread_valid_holds", 32'(data_valid), 32'h1);

    // Reset in the middle of data bit 4, then a clean frame.
    bits = {1'b1, 1'b1, 8'h77, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = bits[i];
      tick(2);
    end
    rx = bits[5];
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("midrst_data",  32'(data_out),   32'h0);
    check("midrst_valid", 32'(data_valid), 32'h0);
    check("midrst_busy",  32'(busy),       32'h0);
    rx = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    drive_frame(0, 8'h5A, 1'b1, 1'b1, 2);
    tick(2);
    check("post_rst_data",   32'(data_out),     32'h5A);
    check("post_rst_valid",  32'(data_valid),   32'h1);
    check("post_rst_parity", 32'(parity_error), 32'h0);

    // Eight clocks per bit: a two-cycle low glitch is rejected.
    base = fe8_cnt;
    rx8 = 1'b0;
    tick(2);
    rx8 = 1'b1;
    tick(2);
    check("glitch_start_seen", 32'(busy8), 32'h1);
    tick(6);
    check("glitch_back_idle", 32'(busy8),          32'h0);
    check("glitch_no_valid",  32'(data_valid8),    32'h0);
    check("glitch_no_parity", 32'(parity_error8),  32'h0);
    check("glitch_no_fe",     32'(fe8_cnt - base), 32'h0);
`ifdef UART_RX_OVERRUN_EN
    check("glitch_no_overrun", 32'(overrun8), 32'h0);
`endif

    // Eight clocks per bit: a normal frame still arrives intact.
    drive_frame(1, 8'hC3, 1'b1, 1'b1, 8);
    check("cpb8_data",   32'(data_out8),     32'hC3);
    check("cpb8_valid",  32'(data_valid8),   32'h1);
    check("cpb8_parity", 32'(parity_error8), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
